clk_ratio_meter: RTL
====================

Name: clk_ratio_meter

Overview:
Measures an incoming divided or fractional clock against the system clock. It counts system clock cycles between consecutive rising edges of meas_clk, then reports the sum, minimum and maximum period over a window of WIN_EDGES periods. It sits on the consumer side of the team's fractional dividers, e.g. an 8.7 divider alternating 8- and 9-cycle periods, for self-check and lock monitoring.

Parameters:
WIN_EDGES, 10, number of meas_clk periods per measurement window (>=2)
CNT_W, 8, width of the single-period counter and of period_min/period_max
ACC_W, 12, width of the window accumulator ratio_sum
SYNC_STAGES, 2, synchronizer flops on meas_clk (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
meas_clk  input  1  clock under measurement, asynchronous to clk
enable  input  1  level; high = measure continuously
ratio_sum  output  ACC_W  sum of clk cycles over last completed window
period_min  output  CNT_W  shortest period in last window
period_max  output  CNT_W  longest period in last window
result_valid  output  1  one-cycle pulse when the three results update
overflow  output  1  sticky; a period counter or accumulator saturated in the last window
busy  output  1  high in ARM or MEASURE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizer flops 0, period_min internal tracker = all-ones.
- Sync: meas_clk passes through SYNC_STAGES flops. rise = last_stage & ~prev_stage. A meas_clk rising edge is detected SYNC_STAGES+1 clk edges later.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE -> ARM when enable=1.
  - ARM: waits for the first rise. On rise, go to MEASURE with per_cnt=1, edge_cnt=0, acc=0, min tracker=all-ones, max tracker=0.
  - MEASURE: per_cnt increments each cycle without a rise. On rise, the captured period equals per_cnt. With this definition, a rise every N clks gives period N. At the same time:
    - acc += period
    - min/max trackers update
    - edge_cnt++
    - per_cnt reloads to 1
  - Window close: on the rise that makes edge_cnt==WIN_EDGES, the outputs ratio_sum/period_min/period_max/overflow load on the next clk edge, including that period. result_valid is high for that one cycle. The closing rise also acts as the start of the next window: accumulators clear to the new-window state and the FSM stays in MEASURE. Back-to-back windows have no gap.
  - enable=0 in any state -> IDLE on the next edge. Any partial window is discarded, no result_valid, and result outputs hold their last values.
- Saturation: per_cnt stops at 2^CNT_W-1 and acc stops at 2^ACC_W-1. Either saturation sets the window's internal overflow flag, which is reported with the window result. The flag clears at each window start.
- Simultaneous enable fall and window-close rise: enable wins, no result_valid.
- Reset mid-window: immediate return to reset state.
- busy = (state != IDLE).

Optional Feature:
Macro CRM_TIMEOUT_EN.
- Defined: adds output timeout (1 bit, one-cycle pulse). If per_cnt reaches 2^CNT_W-1 in ARM or MEASURE, the FSM aborts to IDLE and pulses timeout. No result_valid is issued and results are held. If enable is still high, IDLE re-enters ARM next cycle.
- Not defined: no timeout port. A stalled meas_clk saturates per_cnt, which is flagged via overflow when the window eventually closes.

Test Plan:
- Periods 8,8,8,9,9,9,9,9,9,9 repeating (8.7 pattern), enable=1 -> result_valid every 87 clks after the first window, ratio_sum=87, period_min=8, period_max=9, overflow=0.
- Constant period 4 -> ratio_sum=40, min=max=4. First result_valid occurs exactly 40 clks after the first detected rise, plus one register cycle.
- Drop enable after 5 periods, re-raise after 20 clks -> no result_valid for the partial window, prior results held, busy low while disabled. The next window is measured fresh starting from ARM.
- One 300-clk period inside a window with CNT_W=8 and macro undefined -> that period reads 255, overflow=1 for that window, and overflow is 0 again in the next clean window.
- Macro defined, meas_clk held low after arming -> timeout pulse 254 clks after the arming rise, FSM returns to IDLE then ARM, no result_valid.
- Assert rst mid-window -> all outputs 0 in the same cycle. After release with enable=1, the FSM goes through ARM and the first window reports correct values.

Source files
------------

// File: rtl/clk_ratio_meter.sv
// ---------------------------------------------------------------------------
// clk_ratio_meter : counts clk cycles per meas_clk period and reports the
// window sum/min/max. Optional macro CRM_TIMEOUT_EN adds a stall timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_ratio_meter #(
  parameter int WIN_EDGES   = 10,
  parameter int CNT_W       = 8,
  parameter int ACC_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             enable,
  output logic [ACC_W-1:0] ratio_sum,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy
`ifdef CRM_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam int EW = $clog2(WIN_EDGES + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
  localparam logic [EW-1:0]    LAST_EDGE = EW'(WIN_EDGES - 1);

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [EW-1:0]          edge_cnt_q, edge_cnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       min_q, min_d;
  logic [CNT_W-1:0]       max_q, max_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_W-1:0]       ratio_sum_q, ratio_sum_d;
  logic [CNT_W-1:0]       period_min_q, period_min_d;
  logic [CNT_W-1:0]       period_max_q, period_max_d;
  logic                   valid_q, valid_d;
  logic                   overflow_q, overflow_d;
`ifdef CRM_TIMEOUT_EN
  logic                   timeout_q, timeout_d;
`endif

  logic             rise;
  logic [ACC_W:0]   acc_wide;
  logic             acc_sat;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] min_next;
  logic [CNT_W-1:0] max_next;
  logic             per_sat;
  logic [CNT_W-1:0] per_inc;

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign acc_wide = {1'b0, acc_q} + (ACC_W+1)'(per_cnt_q);
  assign acc_sat  = acc_wide[ACC_W];
  assign acc_next = acc_sat ? ACC_MAX : acc_wide[ACC_W-1:0];
  assign min_next = (per_cnt_q < min_q) ? per_cnt_q : min_q;
  assign max_next = (per_cnt_q > max_q) ? per_cnt_q : max_q;
  assign per_sat  = (per_cnt_q == CNT_MAX);
  assign per_inc  = per_sat ? per_cnt_q : per_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], meas_clk};
    prev_d       = sync_q[SYNC_STAGES-1];
    per_cnt_d    = per_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    acc_d        = acc_q;
    min_d        = min_q;
    max_d        = max_q;
    ovf_d        = ovf_q;
    ratio_sum_d  = ratio_sum_q;
    period_min_d = period_min_q;
    period_max_d = period_max_q;
    overflow_d   = overflow_q;
    valid_d      = 1'b0;
`ifdef CRM_TIMEOUT_EN
    timeout_d    = 1'b0;
`endif

    if (!enable) begin
      // Dropping enable discards any partial window; results hold.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_ARM;
          per_cnt_d = '0;
        end
        S_ARM: begin
          if (rise) begin
            state_d    = S_MEAS;
            per_cnt_d  = CNT_W'(1);
            edge_cnt_d = '0;
            acc_d      = '0;
            min_d      = '1;
            max_d      = '0;
            ovf_d      = 1'b0;
          end else begin
            per_cnt_d = per_inc;
`ifdef CRM_TIMEOUT_EN
            if (per_inc == CNT_MAX && !per_sat) begin
              state_d   = S_IDLE;
              timeout_d = 1'b1;
            end
`endif
          end
        end
        S_MEAS: begin
          if (rise) begin
            per_cnt_d  = CNT_W'(1);
            acc_d      = acc_next;
            min_d      = min_next;
            max_d      = max_next;
            ovf_d      = ovf_q | acc_sat;
            edge_cnt_d = edge_cnt_q + 1'b1;
            if (edge_cnt_q == LAST_EDGE) begin
              // Closing rise publishes the window and opens the next one.
              ratio_sum_d  = acc_next;
              period_min_d = min_next;
              period_max_d = max_next;
              overflow_d   = ovf_q | acc_sat;
              valid_d      = 1'b1;
              edge_cnt_d   = '0;
              acc_d        = '0;
              min_d        = '1;
              max_d        = '0;
              ovf_d        = 1'b0;
            end
          end else begin
            per_cnt_d = per_inc;
            if (per_sat) begin
              ovf_d = 1'b1;
            end
`ifdef CRM_TIMEOUT_EN
            if (per_inc == CNT_MAX && !per_sat) begin
              state_d   = S_IDLE;
              timeout_d = 1'b1;
            end
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      per_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      acc_q        <= '0;
      min_q        <= '1;
      max_q        <= '0;
      ovf_q        <= 1'b0;
      ratio_sum_q  <= '0;
      period_min_q <= '0;
      period_max_q <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef CRM_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      per_cnt_q    <= per_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      acc_q        <= acc_d;
      min_q        <= min_d;
      max_q        <= max_d;
      ovf_q        <= ovf_d;
      ratio_sum_q  <= ratio_sum_d;
      period_min_q <= period_min_d;
      period_max_q <= period_max_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
`ifdef CRM_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign ratio_sum    = ratio_sum_q;
  assign period_min   = period_min_q;
  assign period_max   = period_max_q;
  assign result_valid = valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != S_IDLE);
`ifdef CRM_TIMEOUT_EN
  assign timeout      = timeout_q;
`endif

endmodule

`default_nettype wire
